// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display driver and the scan capture.
// Patterns are active-low, bit6=g .. bit0=a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        TRACK,
        HELD
    } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Inverse of the driver's digit table: segment pattern back to BCD.
// Patterns outside the table are flagged invalid.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] digit,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        digit   = 4'd0;
        blank   = 1'b0;
        invalid = 1'b0;
        unique case (pat)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each
// (seg, an) pair and assembles full frames of decoded BCD digits.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] bcd,
    output logic [NDIG-1:0]   blank,
    output logic              valid,
    output logic              err
);

    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);
    localparam logic [NDIG-1:0] ALL = '1;

    logic [6:0]      seg_m, s_seg, prev_seg;
    logic [NDIG-1:0] an_m, s_an, prev_an;

    cap_state_e      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            take;
    logic            changed;

    logic [3:0]      dec_digit;
    logic            dec_blank;
    logic            dec_bad;

    logic [NDIG-1:0]   sel;
    logic              one;
    logic              cap_ok;
    logic              cap_err;
    logic [NDIG-1:0]   mask, mask_nxt;
    logic              full;
    logic [4*NDIG-1:0] slot_bcd, frame_bcd;
    logic [NDIG-1:0]   slot_blk, frame_blk;

    // Idle bus is all ones, so that is the reset value of the sync chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m    <= '1;
            s_seg    <= '1;
            prev_seg <= '1;
            an_m     <= '1;
            s_an     <= '1;
            prev_an  <= '1;
        end else begin
            seg_m    <= seg;
            s_seg    <= seg_m;
            prev_seg <= s_seg;
            an_m     <= an;
            s_an     <= an_m;
            prev_an  <= s_an;
        end
    end

    assign changed = (s_seg != prev_seg) || (s_an != prev_an);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TRACK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        if (changed) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
        end else if (state == TRACK) begin
            if (cnt == LAST) begin
                take      = 1'b1;
                state_nxt = HELD;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    seg7_decode u_dec (
        .pat     (s_seg),
        .digit   (dec_digit),
        .blank   (dec_blank),
        .invalid (dec_bad)
    );

    // Idle (no anode) and ghosting (several anodes) are both ignored.
    assign sel     = ~s_an;
    assign one     = $onehot(sel);
    assign cap_ok  = take && one && !dec_bad;
    assign cap_err = take && one && dec_bad;
    assign mask_nxt = mask | sel;
    assign full    = cap_ok && (mask_nxt == ALL);

    always_comb begin
        frame_bcd = slot_bcd;
        frame_blk = slot_blk;
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) begin
                frame_bcd[4*i +: 4] = dec_digit;
                frame_blk[i]        = dec_blank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask     <= '0;
            slot_bcd <= '0;
            slot_blk <= '1;
            bcd      <= '0;
            blank    <= '1;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= cap_err;
            if (cap_ok) begin
                slot_bcd <= frame_bcd;
                slot_blk <= frame_blk;
                if (full) begin
                    bcd   <= frame_bcd;
                    blank <= frame_blk;
                    valid <= 1'b1;
                    mask  <= '0;
                end else begin
                    mask <= mask_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (NDIG=4, STABLE=4).
// Each task resets, drives a scenario and checks against hand values.
module tb_seg7_scan_capture;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b0001000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7f;
    logic [3:0]  an = 4'hf;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int vcyc = 0;
    int last_c = 0;
    int c3 = 0;

    seg7_scan_capture #(.NDIG(4), .STABLE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .seg   (seg),
        .an    (an),
        .bcd   (bcd),
        .blank (blank),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
        end
        if (err) ecnt = ecnt + 1;
        if (valid && err) both = both + 1;
    end

    // Called just after an edge; holds the pair for n sampling edges.
    task automatic drive(input logic [6:0] s, input logic [3:0] a,
                         input int n);
        seg = s;
        an = a;
        last_c = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [6:0] d3,
                        input int n2);
        drive(d0, 4'b1110, 8);
        drive(d1, 4'b1101, 8);
        drive(d2, 4'b1011, n2);
        drive(d3, 4'b0111, 8);
        c3 = last_c;
        drive(PB, 4'b1111, 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg = PB;
        an = 4'hf;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int v0, e0;
        do_reset();
        checks++;
        if (bcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bcd: got %h want 0000", bcd);
        end
        checks++;
        if (blank !== 4'hf) begin
            errors++;
            $display("FAIL reset_blank: got %b want 1111", blank);
        end
        checks++;
        if (valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got v=%b e=%b want 0 0",
                     valid, err);
        end
        v0 = vcnt;
        e0 = ecnt;
        drive(PB, 4'b1111, 50);
        checks++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin
            errors++;
            $display("FAIL idle_pulses: got v=%0d e=%0d want 0 0",
                     vcnt - v0, ecnt - e0);
        end
        checks++;
        if (bcd !== 16'h0000 || blank !== 4'hf) begin
            errors++;
            $display("FAIL idle_out: got %h/%b want 0000/1111",
                     bcd, blank);
        end
    endtask

    task automatic test_scan();
        int v0, e0;
        do_reset();
        v0 = vcnt;
        e0 = ecnt;
        scan(P4, P3, P2, P1, 8);
        checks++;
        if (vcnt - v0 !== 1) begin
            errors++;
            $display("FAIL scan_valid_count: got %0d want 1", vcnt - v0);
        end
        checks++;
        if (bcd !== 16'h1234) begin
            errors++;
            $display("FAIL scan_bcd: got %h want 1234", bcd);
        end
        checks++;
        if (blank !== 4'b0000) begin
            errors++;
            $display("FAIL scan_blank: got %b want 0000", blank);
        end
        checks++;
        if (vcyc !== c3 + 7) begin
            errors++;
            $display("FAIL scan_latency: got edge %0d want %0d",
                     vcyc, c3 + 7);
        end
        checks++;
        if (ecnt - e0 !== 0) begin
            errors++;
            $display("FAIL scan_err: got %0d want 0", ecnt - e0);
        end
    endtask

    task automatic test_partial();
        int v0, v1;
        do_reset();
        v0 = vcnt;
        scan(P4, P3, P2, P1, 3);
        checks++;
        if (vcnt - v0 !== 0 || bcd !== 16'h0000) begin
            errors++;
            $display("FAIL partial_pass: got v=%0d bcd=%h want 0 0000",
                     vcnt - v0, bcd);
        end
        v1 = vcnt;
        scan(P4, P3, P2, P1, 8);
        checks++;
        if (vcnt - v1 !== 1) begin
            errors++;
            $display("FAIL partial_next_count: got %0d want 1",
                     vcnt - v1);
        end
        checks++;
        if (bcd !== 16'h1234 || blank !== 4'b0000) begin
            errors++;
            $display("FAIL partial_next_bcd: got %h/%b want 1234/0000",
                     bcd, blank);
        end
    endtask

    task automatic test_invalid();
        int v0, e0, v1;
        do_reset();
        v0 = vcnt;
        e0 = ecnt;
        scan(P4, PX, P2, P1, 8);
        checks++;
        if (ecnt - e0 !== 1) begin
            errors++;
            $display("FAIL invalid_err_count: got %0d want 1", ecnt - e0);
        end
        checks++;
        if (vcnt - v0 !== 0) begin
            errors++;
            $display("FAIL invalid_no_valid: got %0d want 0", vcnt - v0);
        end
        v1 = vcnt;
        scan(P4, P3, P2, P1, 8);
        checks++;
        if (vcnt - v1 !== 1 || bcd !== 16'h1234) begin
            errors++;
            $display("FAIL invalid_repair: got v=%0d bcd=%h want 1 1234",
                     vcnt - v1, bcd);
        end
        checks++;
        if (ecnt - e0 !== 1) begin
            errors++;
            $display("FAIL invalid_repair_err: got %0d want 1", ecnt - e0);
        end
    endtask

    task automatic test_ghost_blank();
        int v0, e0;
        do_reset();
        v0 = vcnt;
        e0 = ecnt;
        drive(P5, 4'b1100, 10);
        drive(PB, 4'b1111, 8);
        checks++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin
            errors++;
            $display("FAIL ghost_pulses: got v=%0d e=%0d want 0 0",
                     vcnt - v0, ecnt - e0);
        end
        scan(P4, P3, P2, PB, 8);
        checks++;
        if (vcnt - v0 !== 1) begin
            errors++;
            $display("FAIL blank_count: got %0d want 1", vcnt - v0);
        end
        checks++;
        if (bcd !== 16'h0234 || blank !== 4'b1000) begin
            errors++;
            $display("FAIL blank_frame: got %h/%b want 0234/1000",
                     bcd, blank);
        end
    endtask

    task automatic test_midreset();
        int v0;
        do_reset();
        drive(P4, 4'b1110, 8);
        drive(P3, 4'b1101, 8);
        drive(P2, 4'b1011, 8);
        do_reset();
        v0 = vcnt;
        drive(P1, 4'b0111, 8);
        drive(PB, 4'b1111, 6);
        checks++;
        if (vcnt - v0 !== 0) begin
            errors++;
            $display("FAIL midreset_valid: got %0d want 0", vcnt - v0);
        end
        checks++;
        if (bcd !== 16'h0000 || blank !== 4'hf) begin
            errors++;
            $display("FAIL midreset_out: got %h/%b want 0000/1111",
                     bcd, blank);
        end
        scan(P4, P3, P2, P1, 8);
        checks++;
        if (vcnt - v0 !== 1 || bcd !== 16'h1234) begin
            errors++;
            $display("FAIL midreset_recap: got v=%0d bcd=%h want 1 1234",
                     vcnt - v0, bcd);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        do_reset();
        v0 = vcnt;
        scan(P9, P0, P8, P7, 8);
        checks++;
        if (vcnt - v0 !== 1 || bcd !== 16'h7809) begin
            errors++;
            $display("FAIL b2b_first: got v=%0d bcd=%h want 1 7809",
                     vcnt - v0, bcd);
        end
        scan(P6, P5, P0, P0, 8);
        checks++;
        if (vcnt - v0 !== 2 || bcd !== 16'h0056) begin
            errors++;
            $display("FAIL b2b_second: got v=%0d bcd=%h want 2 0056",
                     vcnt - v0, bcd);
        end
        checks++;
        if (blank !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_blank: got %b want 0000", blank);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_partial();
        test_invalid();
        test_ghost_blank();
        test_midreset();
        test_back_to_back();
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL valid_err_overlap: got %0d want 0", both);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
Receive-side counterpart of our 7-segment digit driver. It samples a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and decodes each stable digit pattern back to BCD. It assembles a full NDIG-digit frame and publishes it with a one-cycle valid strobe. Used to loop back and self-check display outputs, or to read an external display module.

Parameters:
NDIG, 4, number of multiplexed digits (anode lines); 2..8.
STABLE, 4, consecutive cycles a synchronised (seg, an) pair must hold before it is captured; 1..255.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
seg  in  7  segment lines, active-low, bit6=g … bit0=a.
an  in  NDIG  digit selects, active-low; bit i = digit i (digit 0 = least significant).
bcd  out  4*NDIG  captured frame; nibble i = digit i.
blank  out  NDIG  bit i = digit i captured as blank (all segments off); nibble i then 0.
valid  out  1  one-cycle pulse when bcd/blank update.
err  out  1  one-cycle pulse on a stable, selected, undecodable pattern.

Behaviour:
- Reset is asynchronous and active-high: bcd=0, blank=all ones, valid=0, err=0, slot mask=0, cnt=0, state=TRACK, sync and prev registers=all ones (idle bus). Reset mid-frame discards partial captures.
- seg and an each pass through a two-flop synchroniser -> s_seg, s_an. prev_seg/prev_an register s_* every cycle.
- Decode table (s_seg -> digit): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 1111111=blank. Any other pattern is invalid.
- FSM states: TRACK (counting stability), HELD (current pair already processed; wait for change).
- Every edge: if (s_seg,s_an) != (prev_seg,prev_an): cnt<=0, state<=TRACK. Otherwise, in TRACK: if cnt==STABLE-1, process the pair and go to HELD; else cnt<=cnt+1. HELD: no action.
- Process: if s_an is not exactly one zero (all high = idle, or several low = ghosting), ignore; no err. Else with selected slot i: valid pattern -> write digit/blank into slot buffer i and set mask[i]. Invalid pattern -> err pulse, slot unchanged, mask[i] unchanged.
- Recapturing slot i before the frame completes overwrites it (newest wins).
- When a capture makes mask all ones, on that same edge bcd<=slot buffer including the new digit, blank<=its blank bits, valid<=1, mask<=0. Otherwise valid=0.
- Latency: pin change sampled at edge P -> s_* at P+1 -> capture/valid at edge P+1+STABLE+1 (P+6 for STABLE=4).
- cnt width = clog2(STABLE). cnt saturates in HELD because there is no increment there.
- Outputs hold between frames. err and valid are never asserted together from the same capture.

Decomposition:
- Package seg7_pkg: SEG_0..SEG_9 and SEG_BLANK 7-bit active-low constants, shared with the driver. Also a state enum {TRACK, HELD}.
- Sub-module seg7_decode (combinational): 7-bit pattern -> 4-bit digit, blank, invalid. The driver's inverse table lives in one place.

Test Plan:
- Reset, then idle bus (seg=1111111, an=1111) for 50 cycles -> valid and err never pulse; bcd=0, blank=1111.
- Scan an=1110/1101/1011/0111 with seg=SEG_4/SEG_3/SEG_2/SEG_1, 8 cycles each -> single valid pulse, bcd=16'h1234, blank=0000, pulse at edge P+6 after the last digit's pin change.
- Same scan, but hold digit 2 for only 3 cycles -> no valid in that pass. On the next full pass -> valid with bcd=16'h1234.
- Digit 1 driven seg=0001000 (invalid), stable 8 cycles -> err pulses exactly once, no valid. Repair the pattern to SEG_3 and rescan -> valid, bcd=16'h1234.
- an=1100 (two digits low) for 10 cycles -> no capture, no err. Digit 3 driven SEG_BLANK -> blank=1000, nibble 3=0.
- Assert rst after three digits captured, then deassert and scan only digit 3 -> no valid until all four digits are recaptured.
